// File: rtl/rom_arbiter_if.sv
// Request/grant, read-data and ROM-port signals of the two-requester ROM arbiter.
// The master modport is the arbiter's view; slave is the requesters'/ROM view.
interface rom_arbiter_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
);
  logic                     sink_req0;
  logic [ADDRESS_WIDTH-1:0] sink_addr0;
  logic                     sink_req1;
  logic [ADDRESS_WIDTH-1:0] sink_addr1;
  logic                     src_gnt0;
  logic                     src_gnt1;
  logic                     src_valid0;
  logic                     src_valid1;
  logic [DATA_WIDTH-1:0]    src_data;
  logic [ADDRESS_WIDTH-1:0] src_rom_address;
  logic                     src_rom_ren;
  logic                     src_rom_cen;
  logic [DATA_WIDTH-1:0]    sink_rom_data;
  logic                     src_busy;

  modport master (
    input  sink_req0, sink_addr0, sink_req1, sink_addr1, sink_rom_data,
    output src_gnt0, src_gnt1, src_valid0, src_valid1, src_data,
           src_rom_address, src_rom_ren, src_rom_cen, src_busy
  );

  modport slave (
    output sink_req0, sink_addr0, sink_req1, sink_addr1, sink_rom_data,
    input  src_gnt0, src_gnt1, src_valid0, src_valid1, src_data,
           src_rom_address, src_rom_ren, src_rom_cen, src_busy
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one single-port ROM between two requesters;
// one read per two cycles, all outputs registered.
module rom_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic          clk,
  input  logic          rst,
  rom_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     owner_q, owner_d;
  logic                     last_q, last_d;
  logic                     gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                     valid0_q, valid0_d, valid1_q, valid1_d;
  logic                     en_q, en_d;
  logic                     busy_q, busy_d;
  logic                     win;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    owner_d  = owner_q;
    last_d   = last_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    en_d     = 1'b0;
    // On a tie the requester not served last wins; otherwise the sole requester.
    win = (bus.sink_req0 && bus.sink_req1) ? ~last_q : bus.sink_req1;

    case (state_q)
      ISSUE: begin
        data_d   = bus.sink_rom_data;
        valid0_d = ~owner_q;
        valid1_d = owner_q;
        state_d  = RESP;
      end
      default: begin
        // IDLE and RESP both arbitrate among the current requests.
        if (bus.sink_req0 || bus.sink_req1) begin
          state_d = ISSUE;
          addr_d  = win ? bus.sink_addr1 : bus.sink_addr0;
          owner_d = win;
          last_d  = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          en_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.src_gnt0        = gnt0_q;
  assign bus.src_gnt1        = gnt1_q;
  assign bus.src_valid0      = valid0_q;
  assign bus.src_valid1      = valid1_q;
  assign bus.src_data        = data_q;
  assign bus.src_rom_address = addr_q;
  assign bus.src_rom_ren     = en_q;
  assign bus.src_rom_cen     = en_q;
  assign bus.src_busy        = busy_q;

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 16: width of ROM word address.
REQ-002 Parameter DATA_WIDTH, default 16: width of ROM data word.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sink_req0  input  1  requester 0 read request, level.
REQ-006 sink_addr0  input  ADDRESS_WIDTH  requester 0 word address.
REQ-007 sink_req1  input  1  requester 1 read request, level.
REQ-008 sink_addr1  input  ADDRESS_WIDTH  requester 1 word address.
REQ-009 src_gnt0 / src_gnt1  output  1 each  one-cycle grant pulse to requester 0 / 1.
REQ-010 src_valid0 / src_valid1  output  1 each  one-cycle read-data-valid pulse to requester 0 / 1.
REQ-011 src_data  output  DATA_WIDTH  read data, shared, meaningful while a src_valid is high.
REQ-012 src_rom_address  output  ADDRESS_WIDTH  address to the single-port ROM.
REQ-013 src_rom_ren  output  1  ROM read enable.
REQ-014 src_rom_cen  output  1  ROM chip enable.
REQ-015 sink_rom_data  input  DATA_WIDTH  ROM data output, updated by the ROM on falling clk edge when cen and ren are both high.
REQ-016 src_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, RESP, all outputs registered.
REQ-018 IDLE: ROM enables low; if any sink_req high, select winner, latch its address into src_rom_address and its index as owner, go ISSUE; else stay IDLE.
REQ-019 ISSUE (exactly one cycle): src_rom_cen=1, src_rom_ren=1, src_rom_address stable; src_gnt[owner]=1; at end of cycle capture sink_rom_data into src_data; go RESP.
REQ-020 RESP (exactly one cycle): src_valid[owner]=1, src_data held, ROM enables low; arbitrate as in IDLE among current requests; winner -> ISSUE, none -> IDLE.
REQ-021 Latency: request first seen at rising edge k -> gnt during cycle k+1 -> valid and data during cycle k+2; peak throughput one read per 2 cycles.
REQ-022 Handshake: requester holds req and addr stable until it samples its gnt high; req sampled during the gnt cycle is ignored; req high after gnt is a new request.
REQ-023 Arbitration round-robin: sole requester wins; on tie, the requester not served last wins; last-served pointer updates on every grant.
REQ-024 Address is latched only at winner selection; changes to sink_addr after selection do not affect the in-flight read.
REQ-025 src_data retains last captured value outside RESP; src_valid0 and src_valid1 never high together; src_gnt0 and src_gnt1 never high together.
REQ-026 src_rom_cen and src_rom_ren high only in ISSUE; never high for two consecutive cycles.
REQ-027 No wrap or width conversion: addresses passed unmodified, full ADDRESS_WIDTH range including all-ones.

Reset
REQ-028 While rst high at a rising edge: FSM -> IDLE, all gnt/valid/rom enables/busy = 0, src_rom_address = 0, src_data = 0, last-served pointer = requester 1 (so requester 0 wins first tie).
REQ-029 Reset mid-ISSUE or mid-RESP aborts the transaction: no valid pulse issued afterwards, request must be re-presented.

Verification
REQ-030 Single read: ROM[0x0010]=0xBEEF, req0=1 addr0=0x0010 -> gnt0 next cycle, valid0 with src_data=0xBEEF following cycle, rom_cen/ren high exactly one cycle.
REQ-031 Tie after reset: req0 addr 0x0001, req1 addr 0x0002 both high, ROM[1]=0x1111, ROM[2]=0x2222 -> requester 0 served first (0x1111), requester 1 granted in RESP+1 cycle, valid1 with 0x2222; 4 cycles total.
REQ-032 Sustained contention: both req held high 8 transactions -> grants alternate 0,1,0,1,...; no back-to-back gnt or ROM enable cycles.
REQ-033 Address change after gnt: addr0 switched 0x0010->0x0020 in gnt cycle -> returned data is ROM[0x0010].
REQ-034 Reset in ISSUE: rst asserted for one cycle during ISSUE -> next cycle all outputs 0, no valid pulse; held req re-arbitrated from IDLE.
REQ-035 Boundary address: addr1=all-ones (0xFFFF) -> src_rom_address=0xFFFF, correct ROM last-word data returned.
